// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide engine.
// Latency: n/a (types, encodings and constant helpers only).
// Backpressure: n/a.
package muldiv_pkg;

  // Operation codes presented on Op.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  // Engine sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Quotient reported for a zero divisor: all ones in the low w bits.
  function automatic logic [MAX_WIDTH-1:0] DIV0_QUOTIENT(input int unsigned w);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Combinational iteration step (shift-add multiply / restoring divide) and final sign fix.
// Latency: 0 cycles (pure combinational; the caller registers every result).
// Backpressure: none; the caller decides when step or fix results are captured.
//
// Ports:
//   is_div, is_acc, acc_sub  - operation class of the in-flight op
//   neg_res, neg_rem         - negate product/quotient, negate remainder
//   div_zero                 - in-flight divide has a zero divisor
//   hi_w, lo_w               - working registers (partial product / remainder+quotient)
//   b_mag, a_raw             - divisor/multiplicand magnitude, original A
//   hi_cur, lo_cur           - architectural HI/LO (accumulate source)
//   hi_step, lo_step         - next working-register values for one iteration
//   hi_fix, lo_fix           - values to commit into HI/LO
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic             is_acc,
  input  logic             acc_sub,
  input  logic             neg_res,
  input  logic             neg_rem,
  input  logic             div_zero,
  input  logic [WIDTH-1:0] hi_w,
  input  logic [WIDTH-1:0] lo_w,
  input  logic [WIDTH-1:0] b_mag,
  input  logic [WIDTH-1:0] a_raw,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  output logic [WIDTH-1:0] hi_step,
  output logic [WIDTH-1:0] lo_step,
  output logic [WIDTH-1:0] hi_fix,
  output logic [WIDTH-1:0] lo_fix
);

  localparam logic [MAX_WIDTH-1:0] DIV0_Q_FULL = DIV0_QUOTIENT(WIDTH);

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   acc_res;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // One iteration. Multiply: {hi,lo} holds partial product with the
  // multiplier in lo; add multiplicand when lo[0] set, then shift right.
  // Divide: hi is the partial remainder, lo shifts the dividend out at the
  // top and collects quotient bits at the bottom.
  always_comb begin
    mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, b_mag} : '0);
    div_shift = {hi_w, lo_w[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - b_mag;
    if (is_div) begin
      hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_step = {lo_w[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_w[WIDTH-1:1]};
    end
  end

  // Sign correction and commit value.
  always_comb begin
    prod    = {hi_w, lo_w};
    prod_s  = neg_res ? ('0 - prod) : prod;
    acc_res = acc_sub ? ({hi_cur, lo_cur} - prod_s) : ({hi_cur, lo_cur} + prod_s);
    quo_s   = neg_res ? ('0 - lo_w) : lo_w;
    rem_s   = neg_rem ? ('0 - hi_w) : hi_w;
    hi_fix  = prod_s[2*WIDTH-1:WIDTH];
    lo_fix  = prod_s[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_fix = a_raw;
        lo_fix = DIV0_Q_FULL[WIDTH-1:0];
      end else begin
        hi_fix = rem_s;
        lo_fix = quo_s;
      end
    end else if (is_acc) begin
      hi_fix = acc_res[2*WIDTH-1:WIDTH];
      lo_fix = acc_res[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning HI/LO; one bit per cycle, then sign fix and commit.
// Latency: op accepted at edge t commits HI/LO with Done at edge t+WIDTH+1; MTHI/MTLO write at t.
// Backpressure: new Start is ignored while Busy; Stall holds the pipeline for HI/LO readers/new ops.
//
// Optional: define MULDIV_MADD_EN to enable MADD/MSUB ({HI,LO} +/- signed A*B);
// otherwise those op codes are never accepted.
//
// Ports:
//   Clk, Reset              - clock (rising edge), synchronous active-high reset
//   Start, Op, A, B         - op request with operands (latched at acceptance)
//   Flush                   - squash the in-flight op (no commit, no Done)
//   HiLoRead                - ID/EX instruction reads HI or LO
//   HIreg_read, LOreg_read  - architectural HI/LO
//   Busy, Done, DivByZero   - iterating, commit pulse, sticky zero-divisor flag
//   Stall                   - Busy & (Start | HiLoRead)
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             HiLoRead,
  output logic [WIDTH-1:0] HIreg_read,
  output logic [WIDTH-1:0] LOreg_read,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic             Stall
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hw_q, hw_d;
  logic [WIDTH-1:0] lw_q, lw_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;
  op_e              op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  op_e              op_in;
  logic             iter_op;
  logic             signed_op;
  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_div, is_acc, acc_sub, div_zero;
  logic [WIDTH-1:0] hi_step, lo_step, hi_fix, lo_fix;

  assign op_in = op_e'(Op);

  // Which op codes start an iteration.
  always_comb begin
    iter_op = 1'b0;
    case (op_in)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: iter_op = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MSUB:                   iter_op = 1'b1;
`else
      OP_MADD, OP_MSUB:                   iter_op = 1'b0;
`endif
      default:                            iter_op = 1'b0;
    endcase
  end

  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV) ||
                     (op_in == OP_MADD) || (op_in == OP_MSUB);
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? ('0 - A) : A;
  assign b_mag     = b_neg ? ('0 - B) : B;

  // A flush in the same IDLE cycle drops the request, including MTHI/MTLO.
  assign accept = (state_q == ST_IDLE) && Start && !Flush;

  assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_acc   = (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign acc_sub  = (op_q == OP_MSUB);
  assign div_zero = is_div && (b_q == '0);

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .is_div   (is_div),
    .is_acc   (is_acc),
    .acc_sub  (acc_sub),
    .neg_res  (neg_q),
    .neg_rem  (rneg_q),
    .div_zero (div_zero),
    .hi_w     (hw_q),
    .lo_w     (lw_q),
    .b_mag    (b_q),
    .a_raw    (a_q),
    .hi_cur   (hi_q),
    .lo_cur   (lo_q),
    .hi_step  (hi_step),
    .lo_step  (lo_step),
    .hi_fix   (hi_fix),
    .lo_fix   (lo_fix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hw_d    = hw_q;
    lw_d    = lw_q;
    b_d     = b_q;
    a_d     = a_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (iter_op) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            hw_d    = '0;
            lw_d    = a_mag;
            b_d     = b_mag;
            a_d     = A;
            op_d    = op_in;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            if ((op_in == OP_DIV) || (op_in == OP_DIVU)) dbz_d = 1'b0;
          end else if (op_in == OP_MTHI) begin
            hi_d = A;
          end else if (op_in == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          hw_d  = hi_step;
          lw_d  = lo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!Flush) begin
          hi_d   = hi_fix;
          lo_d   = lo_fix;
          done_d = 1'b1;
          if (div_zero) dbz_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hw_q    <= '0;
      lw_q    <= '0;
      b_q     <= '0;
      a_q     <= '0;
      op_q    <= OP_MULT;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hw_q    <= hw_d;
      lw_q    <= lw_d;
      b_q     <= b_d;
      a_q     <= a_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign HIreg_read = hi_q;
  assign LOreg_read = lo_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = done_q;
  assign DivByZero  = dbz_q;
  assign Stall      = Busy && (Start || HiLoRead);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit at WIDTH=32.
// Latency: n/a. Backpressure: n/a.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start, Flush, HiLoRead;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] HIreg_read, LOreg_read;
  logic        Busy, Done, DivByZero, Stall;

  int n_vec  = 0;
  int n_miss = 0;
  int cycles, stalls;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .A          (A),
    .B          (B),
    .Flush      (Flush),
    .HiLoRead   (HiLoRead),
    .HIreg_read (HIreg_read),
    .LOreg_read (LOreg_read),
    .Busy       (Busy),
    .Done       (Done),
    .DivByZero  (DivByZero),
    .Stall      (Stall)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one op for a single cycle; returns at the negedge after the accept edge.
  // Operands are then scrambled to show they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = 32'hA5A5_A5A5; B = 32'h5A5A_5A5A;
  endtask

  // Counts Busy cycles (and Stall cycles with HiLoRead held) until the engine goes idle.
  task automatic run_to_done(input logic hilo, output int n_busy, output int n_stall);
    n_busy = 0; n_stall = 0;
    HiLoRead = hilo;
    #1;
    while (Busy && n_busy < 200) begin
      n_busy++;
      if (Stall) n_stall++;
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    check_val({tag, "_hi"}, 64'(HIreg_read), 64'(hi));
    check_val({tag, "_lo"}, 64'(LOreg_read), 64'(lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; HiLoRead = 1'b0;
    Op = 3'd0; A = '0; B = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_hilo("reset", 32'h0, 32'h0);
    check_val("reset_busy", 64'(Busy), 64'd0);
    check_val("reset_done", 64'(Done), 64'd0);
    check_val("reset_dbz",  64'(DivByZero), 64'd0);
    check_val("reset_stall", 64'(Stall), 64'd0);

    // MULT -3 * 7 with HiLoRead held: Busy and Stall for 33 cycles.
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    run_to_done(1'b1, cycles, stalls);
    check_val("mult_busy_cycles", 64'(cycles), 64'd33);
    check_val("mult_stall_cycles", 64'(stalls), 64'd33);
    check_val("mult_done", 64'(Done), 64'd1);
    check_val("idle_stall", 64'(Stall), 64'd0);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    HiLoRead = 1'b0;
    @(negedge Clk); #1;
    check_val("done_pulse_end", 64'(Done), 64'd0);

    // MULTU max * max.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_done(1'b0, cycles, stalls);
    check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    // MULT most-negative squared = 2^62.
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    run_to_done(1'b0, cycles, stalls);
    check_hilo("mult_minmin", 32'h4000_0000, 32'h0);

    // DIV -7 / 2.
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_to_done(1'b0, cycles, stalls);
    check_val("div_busy_cycles", 64'(cycles), 64'd33);
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIV 7 / -2: remainder follows dividend sign.
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    run_to_done(1'b0, cycles, stalls);
    check_hilo("div_negdiv", 32'h1, 32'hFFFF_FFFD);

    // DIVU 7 / 0.
    issue(3'd3, 32'd7, 32'd0);
    check_val("dbz_before_commit", 64'(DivByZero), 64'd0);
    run_to_done(1'b0, cycles, stalls);
    check_val("div0_busy_cycles", 64'(cycles), 64'd33);
    check_hilo("div0", 32'h7, 32'hFFFF_FFFF);
    check_val("div0_flag", 64'(DivByZero), 64'd1);

    // MULT leaves the sticky flag alone; DIV 8/2 clears it at acceptance.
    issue(3'd1, 32'd2, 32'd3);
    run_to_done(1'b0, cycles, stalls);
    check_val("dbz_sticky", 64'(DivByZero), 64'd1);
    issue(3'd2, 32'd8, 32'd2);
    check_val("dbz_clear", 64'(DivByZero), 64'd0);
    run_to_done(1'b0, cycles, stalls);
    check_hilo("div_8_2", 32'h0, 32'h4);

    // Signed overflow: most-negative / -1.
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_to_done(1'b0, cycles, stalls);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);
    check_val("div_ovf_flag", 64'(DivByZero), 64'd0);

    // Flush mid-run (with a Start that must be ignored), then Flush+Start in IDLE.
    issue(3'd0, 32'd5, 32'd6);
    repeat (9) @(negedge Clk);
    Flush = 1'b1; Start = 1'b1; Op = 3'd4; A = 32'h0000_DEAD;
    @(negedge Clk);
    Flush = 1'b0; Start = 1'b0;
    #1;
    check_val("flush_busy", 64'(Busy), 64'd0);
    check_val("flush_done", 64'(Done), 64'd0);
    check_hilo("flush", 32'h0, 32'h8000_0000);
    Flush = 1'b1; Start = 1'b1; Op = 3'd5; A = 32'h0000_0077;
    @(negedge Clk);
    Flush = 1'b0; Start = 1'b0;
    #1;
    check_hilo("flush_idle_start", 32'h0, 32'h8000_0000);
    check_val("flush_no_done", 64'(Done), 64'd0);

    // MTLO / MTHI write at the accept edge without going busy.
    issue(3'd5, 32'h0000_1234, 32'h0);
    #1;
    check_val("mtlo_lo", 64'(LOreg_read), 64'h1234);
    check_val("mtlo_busy", 64'(Busy), 64'd0);
    check_val("mtlo_done", 64'(Done), 64'd0);
    issue(3'd4, 32'h0000_ABCD, 32'h0);
    #1;
    check_val("mthi_hi", 64'(HIreg_read), 64'hABCD);

    // Start while busy is stalled and ignored.
    issue(3'd1, 32'd3, 32'd4);
    repeat (5) @(negedge Clk);
    Start = 1'b1; Op = 3'd5; A = 32'h0000_5555;
    #1;
    check_val("busy_start_stall", 64'(Stall), 64'd1);
    @(negedge Clk);
    Start = 1'b0;
    run_to_done(1'b0, cycles, stalls);
    check_hilo("busy_start_ignored", 32'h0, 32'hC);

    // Reset partway through a divide.
    issue(3'd2, 32'd100, 32'd7);
    repeat (18) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    #1;
    check_hilo("midreset", 32'h0, 32'h0);
    check_val("midreset_busy", 64'(Busy), 64'd0);
    check_val("midreset_done", 64'(Done), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // MADD / MSUB, enabled or treated as no-ops.
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd6, 32'd2, 32'd3);
`ifdef MULDIV_MADD_EN
    run_to_done(1'b0, cycles, stalls);
    check_val("madd_busy_cycles", 64'(cycles), 64'd33);
    check_hilo("madd", 32'h0, 32'd11);
    issue(3'd7, 32'hFFFF_FFFE, 32'd3);
    run_to_done(1'b0, cycles, stalls);
    check_hilo("msub", 32'h0, 32'd17);
`else
    #1;
    check_val("madd_off_busy", 64'(Busy), 64'd0);
    check_hilo("madd_off", 32'h0, 32'd5);
    issue(3'd7, 32'hFFFF_FFFE, 32'd3);
    #1;
    check_val("msub_off_busy", 64'(Busy), 64'd0);
    check_hilo("msub_off", 32'h0, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
